// File: rtl/stage_ex_md_pkg.sv
// stage_ex_md_pkg: shared PCPUParam definitions (op codes, branch codes, field widths)
package stage_ex_md_pkg;
  localparam int ALU_OP_W = 5;
  localparam int RF_SRC_W = 2;
  localparam int BRANCH_W = 3;
  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 5'h00,
    OP_SUB   = 5'h01,
    OP_AND   = 5'h02,
    OP_OR    = 5'h03,
    OP_SLL   = 5'h04,
    OP_SRL   = 5'h05,
    OP_SRA   = 5'h06,
    OP_PASSA = 5'h07,
    OP_XOR   = 5'h08,
    OP_NOR   = 5'h09,
    OP_SLT   = 5'h0A,
    OP_AUI   = 5'h0B,
    OP_MULT  = 5'h0C,
    OP_MULTU = 5'h0D,
    OP_DIV   = 5'h0E,
    OP_DIVU  = 5'h0F,
    OP_MFHI  = 5'h10,
    OP_MFLO  = 5'h11,
    OP_MTHI  = 5'h12,
    OP_MTLO  = 5'h13
  } alu_op_e;
  typedef enum logic [BRANCH_W-1:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_LTZ  = 3'b011,
    BR_GEZ  = 3'b100,
    BR_LEZ  = 3'b101,
    BR_GTZ  = 3'b110
  } branch_e;
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;
endpackage

// File: rtl/stage_ex_md_muldiv.sv
// ex_muldiv: multi-cycle multiply / restoring divide engine owning HI, LO and the unit FSM
module ex_muldiv
  import stage_ex_md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     opa,
  input  logic [XLEN-1:0]     opb,
  output logic                busy,
  output logic [XLEN-1:0]     hi,
  output logic [XLEN-1:0]     lo
);
  localparam int CW = $clog2(XLEN + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYC - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN-1:0] a_abs, b_abs, rem_n, quo_n, q_fix, r_fix;
  logic [XLEN:0] r_sh, diff;
  logic [2*XLEN-1:0] prod;
  logic mul_op, div_op, sgn, last, ge, div_zero;
  assign mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign hi     = hi_q;
  assign lo     = lo_q;
  // state, counter, HI/LO and divider registers; reset abandons any operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end
  // next state: leave for IDLE on the last cycle or a flush, otherwise track the op in EX
  always_comb begin
    state_d = (flush || last || !(mul_op || div_op)) ? MD_IDLE : mul_op ? MD_MUL : MD_DIV;
    cnt_d   = (state_d == MD_IDLE) ? '0 : idx + 1'b1;
  end
  // outputs: cycle index of the current op, its last cycle, and the stall
  always_comb begin
    idx  = (state_q == MD_IDLE) ? '0 : cnt_q;
    last = (mul_op && idx == MUL_LAST) || (div_op && idx == DIV_LAST);
    busy = (mul_op || div_op) && !last;
  end
  // datapath: magnitude divider step, sign fix-up, product and HI/LO update
  always_comb begin
    a_abs    = (sgn && opa[XLEN-1]) ? -opa : opa;
    b_abs    = (sgn && opb[XLEN-1]) ? -opb : opb;
    r_sh     = {rem_q, quo_q[XLEN-1]};
    diff     = r_sh - {1'b0, dvs_q};
    ge       = !diff[XLEN];
    rem_n    = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    quo_n    = {quo_q[XLEN-2:0], ge};
    q_fix    = (sgn && (opa[XLEN-1] ^ opb[XLEN-1])) ? -quo_n : quo_n;
    r_fix    = (sgn && opa[XLEN-1]) ? -rem_n : rem_n;
    div_zero = (opb == '0);
    prod     = {{XLEN{sgn && opa[XLEN-1]}}, opa} * {{XLEN{sgn && opb[XLEN-1]}}, opb};
    rem_d    = !div_op ? rem_q : (idx == '0) ? '0 : rem_n;
    quo_d    = !div_op ? quo_q : (idx == '0) ? a_abs : quo_n;
    dvs_d    = (div_op && idx == '0) ? b_abs : dvs_q;
    hi_d     = flush ? hi_q :
               (last && mul_op) ? prod[2*XLEN-1:XLEN] :
               (last && div_op) ? (div_zero ? opa : r_fix) :
               (op == OP_MTHI) ? opa : hi_q;
    lo_d     = flush ? lo_q :
               (last && mul_op) ? prod[XLEN-1:0] :
               (last && div_op) ? (div_zero ? '1 : q_fix) :
               (op == OP_MTLO) ? opa : lo_q;
  end
endmodule

// File: rtl/stage_ex_md.sv
// stage_ex_md: EX pipeline stage with ALU, branch resolution and a multi-cycle mult/div unit
module stage_ex_md
  import stage_ex_md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [31:0]         id_inst,
  output logic [31:0]         ex_inst,
  input  logic [ALU_OP_W-1:0] id_op,
  input  logic [XLEN-1:0]     id_opa,
  input  logic [XLEN-1:0]     id_opb,
  output logic [XLEN-1:0]     ex_opResult,
  input  logic                id_memWE,
  output logic                ex_memWE,
  input  logic                id_memRE,
  output logic                ex_memRE,
  input  logic [XLEN-1:0]     id_memData,
  output logic [XLEN-1:0]     ex_memData,
  input  logic                id_rfWE,
  output logic                ex_rfWE,
  input  logic [4:0]          id_rfDst,
  output logic [4:0]          ex_rfDst,
  input  logic [RF_SRC_W-1:0] id_rfSrc,
  output logic [RF_SRC_W-1:0] ex_rfSrc,
  input  logic [BRANCH_W-1:0] id_branchType,
  output logic [BRANCH_W-1:0] ex_branchType,
  output logic                ex_branchPermit,
  output logic                ex_busy,
  output logic                ex_valid
);
  localparam int SHW = $clog2(XLEN);
  typedef struct packed {
    logic [31:0]         inst;
    logic [ALU_OP_W-1:0] op;
    logic [XLEN-1:0]     opa;
    logic [XLEN-1:0]     opb;
    logic                mem_we;
    logic                mem_re;
    logic [XLEN-1:0]     mem_data;
    logic                rf_we;
    logic [4:0]          rf_dst;
    logic [RF_SRC_W-1:0] rf_src;
    logic [BRANCH_W-1:0] branch_type;
  } ex_reg_t;
  ex_reg_t ex_q, ex_d;
  logic [XLEN-1:0] hi, lo, res;
  logic [SHW-1:0] shamt;
  logic res_zero, opb_neg, opb_zero;
  ex_muldiv #(.XLEN(XLEN), .MUL_CYC(MUL_CYC)) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .op   (ex_q.op),
    .opa  (ex_q.opa),
    .opb  (ex_q.opb),
    .busy (ex_busy),
    .hi   (hi),
    .lo   (lo)
  );
  // EX register next value: flush squashes, busy holds, otherwise capture ID
  always_comb begin
    ex_d = flush ? '0 : ex_busy ? ex_q : ex_reg_t'{
      inst: id_inst, op: id_op, opa: id_opa, opb: id_opb, mem_we: id_memWE, mem_re: id_memRE,
      mem_data: id_memData, rf_we: id_rfWE, rf_dst: id_rfDst, rf_src: id_rfSrc,
      branch_type: id_branchType};
  end
  // EX register, cleared to a bubble by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else ex_q <= ex_d;
  end
  // single-cycle ALU plus HI/LO reads; the shift amount comes from opa
  always_comb begin
    shamt = ex_q.opa[SHW-1:0];
    case (ex_q.op)
      OP_ADD:   res = ex_q.opa + ex_q.opb;
      OP_SUB:   res = ex_q.opa - ex_q.opb;
      OP_AND:   res = ex_q.opa & ex_q.opb;
      OP_OR:    res = ex_q.opa | ex_q.opb;
      OP_SLL:   res = ex_q.opb << shamt;
      OP_SRL:   res = ex_q.opb >> shamt;
      OP_SRA:   res = $signed(ex_q.opb) >>> shamt;
      OP_PASSA: res = ex_q.opa;
      OP_XOR:   res = ex_q.opa ^ ex_q.opb;
      OP_NOR:   res = ~(ex_q.opa | ex_q.opb);
      OP_SLT:   res = {{(XLEN-1){1'b0}}, $signed(ex_q.opa) < $signed(ex_q.opb)};
      OP_AUI:   res = ex_q.opa + (ex_q.opb << 16);
      OP_MFHI:  res = hi;
      OP_MFLO:  res = lo;
      default:  res = '0;
    endcase
  end
  // branch resolution: equality on the ALU result, signed sign/zero tests on opb
  always_comb begin
    res_zero = (res == '0);
    opb_neg  = ex_q.opb[XLEN-1];
    opb_zero = (ex_q.opb == '0);
    case (ex_q.branch_type)
      BR_EQ:   ex_branchPermit = res_zero;
      BR_NE:   ex_branchPermit = !res_zero;
      BR_LTZ:  ex_branchPermit = opb_neg;
      BR_GEZ:  ex_branchPermit = !opb_neg;
      BR_LEZ:  ex_branchPermit = opb_neg || opb_zero;
      BR_GTZ:  ex_branchPermit = !opb_neg && !opb_zero;
      default: ex_branchPermit = 1'b0;
    endcase
  end
  assign ex_inst       = ex_q.inst;
  assign ex_opResult   = res;
  assign ex_memWE      = ex_q.mem_we;
  assign ex_memRE      = ex_q.mem_re;
  assign ex_memData    = ex_q.mem_data;
  assign ex_rfWE       = ex_q.rf_we && !ex_busy;
  assign ex_rfDst      = ex_q.rf_dst;
  assign ex_rfSrc      = ex_q.rf_src;
  assign ex_branchType = ex_q.branch_type;
  assign ex_valid      = !ex_busy && (ex_q.inst != 32'd0);
endmodule

// File: tb/tb_stage_ex_md.sv
// tb_stage_ex_md: directed self-checking bench for stage_ex_md
module tb_stage_ex_md;
  import stage_ex_md_pkg::*;
  logic clk = 1'b0;
  logic rst, flush;
  logic [31:0] id_inst, ex_inst;
  logic [ALU_OP_W-1:0] id_op;
  logic [31:0] id_opa, id_opb, ex_opResult, id_memData, ex_memData;
  logic id_memWE, ex_memWE, id_memRE, ex_memRE, id_rfWE, ex_rfWE;
  logic [4:0] id_rfDst, ex_rfDst;
  logic [RF_SRC_W-1:0] id_rfSrc, ex_rfSrc;
  logic [BRANCH_W-1:0] id_branchType, ex_branchType;
  logic ex_branchPermit, ex_busy, ex_valid;
  int n_checks = 0;
  int n_errors = 0;
  int busy_n;

  always #5 clk = ~clk;

  stage_ex_md #(.XLEN(32), .MUL_CYC(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_inst(id_inst), .ex_inst(ex_inst),
    .id_op(id_op), .id_opa(id_opa), .id_opb(id_opb), .ex_opResult(ex_opResult),
    .id_memWE(id_memWE), .ex_memWE(ex_memWE), .id_memRE(id_memRE), .ex_memRE(ex_memRE),
    .id_memData(id_memData), .ex_memData(ex_memData),
    .id_rfWE(id_rfWE), .ex_rfWE(ex_rfWE), .id_rfDst(id_rfDst), .ex_rfDst(ex_rfDst),
    .id_rfSrc(id_rfSrc), .ex_rfSrc(ex_rfSrc),
    .id_branchType(id_branchType), .ex_branchType(ex_branchType),
    .ex_branchPermit(ex_branchPermit), .ex_busy(ex_busy), .ex_valid(ex_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] inst, input logic [2:0] br);
    id_op = op; id_opa = a; id_opb = b; id_inst = inst; id_branchType = br;
    id_rfWE = 1'b1; id_rfDst = inst[4:0]; id_rfSrc = inst[3:2];
    id_memData = a ^ b; id_memWE = inst[0]; id_memRE = inst[1];
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (ex_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(OP_ADD, 32'd5, 32'd6, 32'h0000_0013, BR_GEZ);
    repeat (2) tick();
    chk("rst_inst", ex_inst, 32'h0);
    chk("rst_res", ex_opResult, 32'h0);
    chk("rst_valid", ex_valid, 32'h0);
    chk("rst_busy", ex_busy, 32'h0);
    chk("rst_rfwe", ex_rfWE, 32'h0);
    chk("rst_permit", ex_branchPermit, 32'h0);
    rst = 1'b1;
    drive(OP_ADD, 32'd7, 32'hFFFF_FFFD, 32'h0000_0021, BR_NONE);
    tick();
    chk("add_res", ex_opResult, 32'd4);
    chk("add_valid", ex_valid, 32'h1);
    chk("add_inst", ex_inst, 32'h0000_0021);
    chk("add_memdata", ex_memData, 32'hFFFF_FFFA);
    chk("add_rfdst", ex_rfDst, 32'h1);
    chk("add_rfwe", ex_rfWE, 32'h1);
    drive(OP_SLL, 32'd4, 32'd1, 32'h40, BR_NONE); tick();
    chk("sll", ex_opResult, 32'h10);
    drive(OP_SRL, 32'd1, 32'h8000_0000, 32'h41, BR_NONE); tick();
    chk("srl", ex_opResult, 32'h4000_0000);
    drive(OP_SRA, 32'd4, 32'h8000_0000, 32'h42, BR_NONE); tick();
    chk("sra", ex_opResult, 32'hF800_0000);
    drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h43, BR_NONE); tick();
    chk("slt", ex_opResult, 32'h1);
    drive(OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h44, BR_NONE); tick();
    chk("nor", ex_opResult, 32'h0000_0F0F);
    drive(OP_AUI, 32'd1, 32'd2, 32'h45, BR_NONE); tick();
    chk("aui", ex_opResult, 32'h0002_0001);
    drive(5'h1F, 32'd9, 32'd9, 32'h46, BR_NONE); tick();
    chk("undef", ex_opResult, 32'h0);
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'h50, BR_NONE); tick();
    chk("mul_busy", ex_busy, 32'h1);
    chk("mul_valid_busy", ex_valid, 32'h0);
    chk("mul_rfwe_busy", ex_rfWE, 32'h0);
    run_busy(busy_n);
    chk("mul_busy_cycles", busy_n, 32'd1);
    chk("mul_valid_last", ex_valid, 32'h1);
    drive(OP_MFLO, 32'd0, 32'd0, 32'h51, BR_NONE); tick();
    chk("mul_lo", ex_opResult, 32'hFFFF_FFF1);
    drive(OP_MFHI, 32'd0, 32'd0, 32'h52, BR_NONE); tick();
    chk("mul_hi", ex_opResult, 32'hFFFF_FFFF);
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h60, BR_NONE); tick();
    run_busy(busy_n);
    chk("div_busy_cycles", busy_n, 32'd32);
    drive(OP_MFLO, 32'd0, 32'd0, 32'h61, BR_NONE); tick();
    chk("div_lo", ex_opResult, 32'hFFFF_FFFD);
    drive(OP_MFHI, 32'd0, 32'd0, 32'h62, BR_NONE); tick();
    chk("div_hi", ex_opResult, 32'hFFFF_FFFF);
    drive(OP_DIVU, 32'd5, 32'd0, 32'h63, BR_NONE); tick();
    run_busy(busy_n);
    chk("divz_busy_cycles", busy_n, 32'd32);
    drive(OP_MFLO, 32'd0, 32'd0, 32'h64, BR_NONE); tick();
    chk("divz_lo", ex_opResult, 32'hFFFF_FFFF);
    drive(OP_MFHI, 32'd0, 32'd0, 32'h65, BR_NONE); tick();
    chk("divz_hi", ex_opResult, 32'd5);
    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h66, BR_NONE); tick();
    run_busy(busy_n);
    drive(OP_MFLO, 32'd0, 32'd0, 32'h67, BR_NONE); tick();
    chk("minov_lo", ex_opResult, 32'h8000_0000);
    drive(OP_MFHI, 32'd0, 32'd0, 32'h68, BR_NONE); tick();
    chk("minov_hi", ex_opResult, 32'h0);
    drive(OP_MTHI, 32'h1234, 32'd0, 32'h70, BR_NONE); tick();
    drive(OP_DIVU, 32'd100, 32'd7, 32'h71, BR_NONE); tick();
    repeat (9) tick();
    chk("flush_pre_busy", ex_busy, 32'h1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_busy", ex_busy, 32'h0);
    chk("flush_inst", ex_inst, 32'h0);
    chk("flush_valid", ex_valid, 32'h0);
    drive(OP_MFHI, 32'd0, 32'd0, 32'h72, BR_NONE); tick();
    chk("flush_hi", ex_opResult, 32'h1234);
    drive(OP_MFLO, 32'd0, 32'd0, 32'h73, BR_NONE); tick();
    chk("flush_lo", ex_opResult, 32'h8000_0000);
    drive(OP_DIVU, 32'd100, 32'd7, 32'h74, BR_NONE); tick();
    run_busy(busy_n);
    drive(OP_MFLO, 32'd0, 32'd0, 32'h75, BR_NONE); tick();
    chk("divu_lo", ex_opResult, 32'd14);
    drive(OP_MFHI, 32'd0, 32'd0, 32'h76, BR_NONE); tick();
    chk("divu_hi", ex_opResult, 32'd2);
    drive(OP_DIVU, 32'd50, 32'd3, 32'h90, BR_NONE); tick();
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    chk("mrst_inst", ex_inst, 32'h0);
    chk("mrst_busy", ex_busy, 32'h0);
    chk("mrst_valid", ex_valid, 32'h0);
    chk("mrst_memdata", ex_memData, 32'h0);
    drive(OP_ADD, 32'd1, 32'd1, 32'hA0, BR_NONE);
    rst = 1'b1;
    tick();
    chk("mrst_add", ex_opResult, 32'd2);
    chk("mrst_add_valid", ex_valid, 32'h1);
    chk("mrst_add_busy", ex_busy, 32'h0);
    drive(OP_MFHI, 32'd0, 32'd0, 32'hA1, BR_NONE); tick();
    chk("mrst_hi", ex_opResult, 32'h0);
    drive(OP_ADD, 32'd0, 32'h8000_0000, 32'hB0, BR_LTZ); tick();
    chk("bltz_min", ex_branchPermit, 32'h1);
    drive(OP_ADD, 32'd0, 32'd0, 32'hB1, BR_GTZ); tick();
    chk("bgtz_zero", ex_branchPermit, 32'h0);
    drive(OP_SUB, 32'd9, 32'd9, 32'hB2, BR_EQ); tick();
    chk("beq_eq", ex_branchPermit, 32'h1);
    drive(OP_SUB, 32'd9, 32'd9, 32'hB3, BR_NE); tick();
    chk("bne_eq", ex_branchPermit, 32'h0);
    drive(OP_ADD, 32'd0, 32'd0, 32'hB4, BR_GEZ); tick();
    chk("bgez_zero", ex_branchPermit, 32'h1);
    drive(OP_ADD, 32'd0, 32'd5, 32'hB5, BR_LEZ); tick();
    chk("blez_pos", ex_branchPermit, 32'h0);
    drive(OP_ADD, 32'd0, 32'd5, 32'hB6, BR_GTZ); tick();
    chk("bgtz_pos", ex_branchPermit, 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stage_ex_md.md
STAGE_EX_MD -- requirements
Module: stage_ex_md

Interface
REQ-001 Parameter XLEN SHALL default to 32: datapath width of operands, results, HI and LO.
REQ-002 Parameter MUL_CYC SHALL default to 2: cycles a multiply occupies EX. Legal range is 1..8.
REQ-003 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of the EX register.
- id_inst  in  32 / ex_inst  out  32  instruction pass-through.
- id_op  in  5  ALU op code.
- id_opa, id_opb  in  XLEN  operands.
- ex_opResult  out  XLEN  result.
- id_memWE/ex_memWE, id_memRE/ex_memRE  in/out  1  memory enables, pass-through.
- id_memData/ex_memData  in/out  XLEN  store data, pass-through.
- id_rfWE/ex_rfWE  in/out  1; id_rfDst/ex_rfDst  in/out  5; id_rfSrc/ex_rfSrc  in/out  RF_SRC width.
- id_branchType/ex_branchType  in/out  BRANCH width.
- ex_branchPermit  out  1  branch taken.
- ex_busy  out  1  EX is occupied by mult/div; ID must hold its outputs stable.
- ex_valid  out  1  ex_* describe a completed instruction this cycle.

Function
REQ-004 The EX register SHALL load all id_* at each rising edge when ex_busy=0. It SHALL hold when ex_busy=1.
REQ-005 Ops 0x0–0xB SHALL be single-cycle combinational, computed from the EX register:
- add, sub, and, or, sll, srl, sra, pass-opa, xor, nor, slt (signed), aui.
- Shift amount is opa[log2(XLEN)-1:0].
REQ-006 New ops:
- 0x0C mult, 0x0D multu: {HI,LO} = opa × opb (2·XLEN bits).
- 0x0E div, 0x0F divu: LO = quotient, HI = remainder.
- 0x10 mfhi, 0x11 mflo: result = HI / LO.
- 0x12 mthi, 0x13 mtlo: HI / LO = opa at the cycle end.
- Undefined codes: result 0.
REQ-007 Multiply SHALL occupy EX for exactly MUL_CYC cycles. Divide SHALL occupy EX for exactly XLEN+1 cycles, using an iterative restoring divider with 1 bit per cycle.
REQ-008 ex_busy SHALL be 1 on every mult/div cycle except the last. On the last cycle's edge, HI/LO are written and the next instruction is loaded at the same edge.
REQ-009 ex_valid SHALL be 0 on busy cycles. Otherwise it SHALL be 1 unless the EX register holds a reset/flush bubble (ex_inst=0).
REQ-010 Signed divide SHALL truncate toward zero; the remainder takes the dividend's sign.
REQ-011 Divide by zero: LO = all ones, HI = dividend.
REQ-012 Signed MIN/−1: LO = MIN, HI = 0.
REQ-013 mult/div ops SHALL force ex_rfWE=0 on their busy cycles.
REQ-014 mfhi/mflo following a mult/div SHALL read the updated HI/LO; this is guaranteed by the REQ-008 stall.
REQ-015 ex_branchPermit SHALL use signed compares on opb:
- 000: 0.
- 001 beq: result==0.
- 010 bne: result!=0.
- 011 bltz: opb<0.
- 100 bgez: opb>=0.
- 101 blez: opb<=0.
- 110 bgtz: opb>0.
- others: 0.
REQ-016 flush SHALL clear the EX register to zero, take precedence over hold, and abort any mult/div in progress. HI/LO stay unchanged and the unit returns to IDLE.
REQ-017 Unit FSM states:
- IDLE→MUL or IDLE→DIV when a mult/div op is in the EX register (counter loaded).
- MUL/DIV→IDLE when the counter reaches its last cycle, or on flush.

Reset
REQ-018 While rst=0, asynchronously:
- All ex_* outputs, HI, LO and the counter SHALL be 0.
- The FSM SHALL be IDLE.
- ex_busy=0, ex_valid=0, ex_branchPermit=0.
REQ-019 Reset asserted mid-divide SHALL abandon the operation. The first instruction after release SHALL execute normally.

Structure
REQ-020 Op codes, ALU_OP width (5), branch codes and RF_SRC/BRANCH widths SHALL live in the shared PCPUParam definitions.
REQ-021 The iterative mult/div engine, HI/LO and the FSM SHALL be one sub-module, ex_muldiv. stage_ex_md holds the EX register, ALU and branch logic.

Verification
REQ-022 add 7+(−3) -> ex_opResult=4, ex_valid=1 the cycle after load.
REQ-023 mult −3×5, MUL_CYC=2 -> ex_busy=1 for 1 cycle; then mflo=0xFFFFFFF1 and mfhi=0xFFFFFFFF.
REQ-024 div −7/2 -> ex_busy=1 for 32 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-025 mthi 0x1234, then divu 100/7 with flush on busy cycle 10 -> ex_busy=0 next cycle; mfhi returns 0x1234.
REQ-026 rst pulsed low on divide cycle 5 -> all outputs 0 immediately; after release, add 1+1 -> 2.
REQ-027 bltz with opb=0x80000000 -> permit=1; bgtz with opb=0 -> permit=0.
